// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 window controller.
//  - default frame geometry and counter widths
//  - controller FSM state type
//  - top-row replicate select encodings
package win_pkg;

  localparam int unsigned H_ACTIVE_DEF  = 640;
  localparam int unsigned V_ACTIVE_DEF  = 480;
  localparam int unsigned COL_W_DEF     = 10;
  localparam int unsigned ROW_W_DEF     = 9;
  localparam int unsigned FLUSH_GAP_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    GAP,
    FLUSH,
    DONE
  } win_state_t;

  localparam logic [1:0] TOP_NORM = 2'd0;  // row >= 2: all three rows real
  localparam logic [1:0] TOP_ROW1 = 2'd1;  // row == 1: top row replicates
  localparam logic [1:0] TOP_ROW0 = 2'd2;  // row == 0: top and middle replicate

endpackage

// File: rtl/line_col_counter.sv
// Column/row position counters for the window controller.
// Ports:
//  clk, rst_n  clock, async active-low reset
//  clear       restart at row 0; a coincident pix counts as column 0
//  pix         a pixel is presented this cycle
//  line_end    end of the current line: row advances, column restarts
//  col         column of the pixel presented this cycle (clamped to H_ACTIVE-1)
//  row         current row, 0..V_ACTIVE
//  pix_ok      current pixel lies within the first H_ACTIVE pixels of its line
//  len_err     pixel count of the current line differs from H_ACTIVE
//  row_last    current row is the last input row
//  col_last    current pixel is column H_ACTIVE-1
module line_col_counter
  import win_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned COL_W    = COL_W_DEF,
  parameter int unsigned ROW_W    = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             pix,
  input  logic             line_end,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             pix_ok,
  output logic             len_err,
  output logic             row_last,
  output logic             col_last
);

  // One extra bit so an overlong line is distinguishable from an exact one;
  // the count saturates at H_ACTIVE+1.
  localparam int unsigned CNT_W = COL_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(H_ACTIVE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H_ACTIVE - 1);

  logic [CNT_W-1:0] pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      row  <= '0;
    end else if (clear) begin
      pcnt <= pix ? CNT_W'(1) : '0;
      row  <= '0;
    end else if (line_end) begin
      pcnt <= '0;
      row  <= row + ROW_W'(1);
    end else if (pix && pcnt != CNT_SAT) begin
      pcnt <= pcnt + CNT_W'(1);
    end
  end

  always_comb begin
    pix_ok   = pcnt < CNT_FULL;
    col      = pix_ok ? pcnt[COL_W-1:0] : COL_W'(H_ACTIVE - 1);
    len_err  = pcnt != CNT_FULL;
    row_last = row == ROW_W'(V_ACTIVE - 1);
    col_last = pcnt == CNT_LAST;
  end

endmodule

// File: rtl/window_ctrl.sv
// Timing/sequence controller for the 3x3 window generator's two line-buffer
// FIFOs. Tracks column/row from VSYNC/HSYNC/BLANK, drives FIFO write/read
// enables and border-replicate selects, and after the last input line
// synthesizes one flush line so the bottom window row drains.
// Ports:
//  clk, rst_n     clock, async active-low reset
//  i_vsync        frame start (rising edge restarts the frame)
//  i_hsync        line sync, delayed 1 cycle to o_hsync
//  i_blank        high = active pixel
//  o_pix_valid    window pixel this cycle (input or flush)
//  o_col, o_row   pixel position (o_row == V_ACTIVE on the flush line)
//  o_lb_wr_en     [0] FIFO1 write, [1] FIFO2 write
//  o_lb_rd_en     [0] FIFO1 read,  [1] FIFO2 read
//  o_first_col    left replicate, o_last_col right replicate
//  o_top_sel      TOP_NORM / TOP_ROW1 / TOP_ROW0
//  o_bot_sel      flush line: bottom row replicates FIFO1
//  o_frame_done   pulse after the last flush pixel
//  o_err_line     pulse: line length != H_ACTIVE
//  o_err_frame    pulse: vsync arrived mid-frame
// All outputs are registered, one cycle after the inputs are sampled.
module window_ctrl
  import win_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned COL_W     = COL_W_DEF,
  parameter int unsigned ROW_W     = ROW_W_DEF,
  parameter int unsigned FLUSH_GAP = FLUSH_GAP_DEF  // must be >= 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_blank,
  output logic             o_hsync,
  output logic             o_pix_valid,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic [1:0]       o_lb_wr_en,
  output logic [1:0]       o_lb_rd_en,
  output logic             o_first_col,
  output logic             o_last_col,
  output logic [1:0]       o_top_sel,
  output logic             o_bot_sel,
  output logic             o_frame_done,
  output logic             o_err_line,
  output logic             o_err_frame
);

  localparam int unsigned GAP_W = $clog2(FLUSH_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(FLUSH_GAP - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(V_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_PENULT = ROW_W'(V_ACTIVE - 2);
  localparam logic [ROW_W-1:0] ROW_FLUSH  = ROW_W'(V_ACTIVE);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(H_ACTIVE - 1);

  win_state_t       state;
  logic             vsync_d;
  logic             in_line;
  logic [GAP_W-1:0] gap_cnt;

  logic             vs_rise, in_frame, line_pix, flush_pix, cnt_pix;
  logic             cnt_clear, line_end, valid;
  logic [COL_W-1:0] cnt_col, eff_col;
  logic [ROW_W-1:0] cnt_row, eff_row;
  logic             pix_ok, len_err, row_last, col_last;
  logic [1:0]       wr_nxt, rd_nxt, top_nxt;

  line_col_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .pix      (cnt_pix),
    .line_end (line_end),
    .col      (cnt_col),
    .row      (cnt_row),
    .pix_ok   (pix_ok),
    .len_err  (len_err),
    .row_last (row_last),
    .col_last (col_last)
  );

  // A vsync rise takes effect in the same cycle: a coincident active pixel is
  // row 0 col 0 of the new frame, so the stale counter values are bypassed.
  always_comb begin
    vs_rise   = i_vsync & ~vsync_d;
    in_frame  = (state == ACTIVE) || (state == GAP) || (state == FLUSH);
    line_pix  = i_blank && (vs_rise || state == ACTIVE);
    flush_pix = !vs_rise && state == FLUSH;
    cnt_pix   = line_pix || flush_pix;
    line_end  = !vs_rise && state == ACTIVE && in_line && !i_blank;
    cnt_clear = vs_rise || state == DONE;
    eff_col   = vs_rise ? '0 : cnt_col;
    eff_row   = vs_rise ? '0 : cnt_row;
    valid     = cnt_pix && (vs_rise || pix_ok);

    wr_nxt  = 2'b00;
    rd_nxt  = 2'b00;
    top_nxt = TOP_NORM;
    // The flush line sits at row V_ACTIVE, so the same row decode yields
    // wr=00 / rd=11 there without a special case.
    if (valid) begin
      wr_nxt = {eff_row <= ROW_PENULT, eff_row <= ROW_LAST};
      rd_nxt = {eff_row > ROW_W'(1), eff_row != '0};
      if (eff_row == '0)
        top_nxt = TOP_ROW0;
      else if (eff_row == ROW_W'(1))
        top_nxt = TOP_ROW1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vsync_d      <= 1'b0;
      in_line      <= 1'b0;
      gap_cnt      <= '0;
      o_hsync      <= 1'b0;
      o_pix_valid  <= 1'b0;
      o_col        <= '0;
      o_row        <= '0;
      o_lb_wr_en   <= '0;
      o_lb_rd_en   <= '0;
      o_first_col  <= 1'b0;
      o_last_col   <= 1'b0;
      o_top_sel    <= '0;
      o_bot_sel    <= 1'b0;
      o_frame_done <= 1'b0;
      o_err_line   <= 1'b0;
      o_err_frame  <= 1'b0;
    end else begin
      vsync_d      <= i_vsync;
      o_hsync      <= i_hsync;
      o_pix_valid  <= valid;
      o_col        <= valid ? eff_col : '0;
      o_row        <= valid ? eff_row : '0;
      o_lb_wr_en   <= wr_nxt;
      o_lb_rd_en   <= rd_nxt;
      o_first_col  <= valid && eff_col == '0;
      o_last_col   <= valid && eff_col == COL_LAST;
      o_top_sel    <= top_nxt;
      o_bot_sel    <= valid && eff_row == ROW_FLUSH;
      o_err_line   <= line_end && len_err;
      o_err_frame  <= vs_rise && in_frame;
      o_frame_done <= 1'b0;

      if (vs_rise) begin
        state   <= ACTIVE;
        in_line <= i_blank;
        gap_cnt <= '0;
      end else begin
        case (state)
          ACTIVE: begin
            in_line <= i_blank;
            if (line_end && row_last)
              state <= GAP;
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= FLUSH;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          FLUSH: begin
            if (col_last)
              state <= DONE;
          end
          DONE: begin
            o_frame_done <= 1'b1;
            state        <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_ctrl.sv
module tb_window_ctrl;

  localparam int H = 8;
  localparam int V = 4;

  typedef struct packed {
    logic       v;
    logic [2:0] col;
    logic [2:0] row;
    logic [1:0] wr;
    logic [1:0] rd;
    logic       first;
    logic       last;
    logic [1:0] top;
    logic       bot;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_vsync = 1'b0, i_hsync = 1'b0, i_blank = 1'b0;
  logic       o_hsync, o_pix_valid, o_first_col, o_last_col, o_bot_sel;
  logic       o_frame_done, o_err_line, o_err_frame;
  logic [2:0] o_col, o_row;
  logic [1:0] o_lb_wr_en, o_lb_rd_en, o_top_sel;

  int tests = 0, fails = 0;
  int cyc = 0, last_flush_cyc = 0, done_gap = 0;
  int n_done = 0, n_err_line = 0, n_err_frame = 0;
  int n_wr0 = 0, n_wr1 = 0, n_rd0 = 0, n_rd1 = 0;
  pix_t q[$];
  pix_t got;

  window_ctrl #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .COL_W     (3),
    .ROW_W     (3),
    .FLUSH_GAP (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_vsync      (i_vsync),
    .i_hsync      (i_hsync),
    .i_blank      (i_blank),
    .o_hsync      (o_hsync),
    .o_pix_valid  (o_pix_valid),
    .o_col        (o_col),
    .o_row        (o_row),
    .o_lb_wr_en   (o_lb_wr_en),
    .o_lb_rd_en   (o_lb_rd_en),
    .o_first_col  (o_first_col),
    .o_last_col   (o_last_col),
    .o_top_sel    (o_top_sel),
    .o_bot_sel    (o_bot_sel),
    .o_frame_done (o_frame_done),
    .o_err_line   (o_err_line),
    .o_err_frame  (o_err_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t exp_pix(input int r, input int c);
    pix_t e;
    e.v     = 1'b1;
    e.col   = 3'(c);
    e.row   = 3'(r);
    e.wr[0] = (r <= V - 1);
    e.wr[1] = (r <= V - 2);
    e.rd[0] = (r >= 1);
    e.rd[1] = (r >= 2);
    e.first = (c == 0);
    e.last  = (c == H - 1);
    e.top   = (r == 0) ? 2'd2 : (r == 1) ? 2'd1 : 2'd0;
    e.bot   = (r == V);
    return e;
  endfunction

  // Scoreboard consumer and event counters.
  always @(negedge clk) begin
    cyc++;
    if (o_pix_valid) begin
      got = {o_pix_valid, o_col, o_row, o_lb_wr_en, o_lb_rd_en,
             o_first_col, o_last_col, o_top_sel, o_bot_sel};
      if (q.size() == 0) chk("unexpected_pix", 32'(got), 32'd0);
      else chk("pix", 32'(got), 32'(q.pop_front()));
      n_wr0 += int'(o_lb_wr_en[0]);
      n_wr1 += int'(o_lb_wr_en[1]);
      n_rd0 += int'(o_lb_rd_en[0]);
      n_rd1 += int'(o_lb_rd_en[1]);
      if (o_bot_sel && o_col == 3'd7) last_flush_cyc = cyc;
    end else begin
      chk("idle_side", {o_lb_wr_en, o_lb_rd_en, o_bot_sel, o_first_col,
                        o_last_col, o_top_sel}, 32'd0);
    end
    if (o_err_line)  n_err_line++;
    if (o_err_frame) n_err_frame++;
    if (o_frame_done) begin
      n_done++;
      done_gap = cyc - last_flush_cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {o_hsync, o_pix_valid, o_col, o_row, o_lb_wr_en, o_lb_rd_en,
              o_first_col, o_last_col, o_top_sel, o_bot_sel, o_frame_done,
              o_err_line, o_err_frame}, 32'd0);
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    tick();
  endtask

  task automatic line(input int n, input int r);
    i_hsync = 1'b1;
    tick();
    i_hsync = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      i_blank = 1'b1;
      if (i < H) q.push_back(exp_pix(r, i));
      tick();
    end
    i_blank = 1'b0;
    repeat (3) tick();
  endtask

  task automatic push_flush();
    for (int c = 0; c < H; c++) q.push_back(exp_pix(V, c));
  endtask

  task automatic clr_counts();
    n_wr0 = 0; n_wr1 = 0; n_rd0 = 0; n_rd1 = 0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 200) begin
      tick();
      k++;
    end
    tick();
    chk("frame_done_cnt", n_done, target);
    chk("done_gap", done_gap, 1);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) tick();
    chk_zero("post_reset_idle");

    // hsync passthrough
    i_hsync = 1'b1;
    tick();
    i_hsync = 1'b0;
    @(negedge clk);
    chk("hsync_hi", o_hsync, 1);
    tick();
    @(negedge clk);
    chk("hsync_lo", o_hsync, 0);
    tick();

    // Frame 1: clean 4x8 frame plus flush
    clr_counts();
    vsync_pulse();
    for (int r = 0; r < V; r++) line(H, r);
    push_flush();
    wait_done(1);
    chk("wr0_cnt", n_wr0, 32);
    chk("wr1_cnt", n_wr1, 24);
    chk("rd0_cnt", n_rd0, 32);
    chk("rd1_cnt", n_rd1, 24);
    chk("err_line_none", n_err_line, 0);
    chk("err_frame_none", n_err_frame, 0);

    // Frame 2: short line at row 1, long line at row 2
    vsync_pulse();
    line(H, 0);
    line(6, 1);
    chk("err_line_short", n_err_line, 1);
    line(10, 2);
    chk("err_line_long", n_err_line, 2);
    line(H, 3);
    push_flush();
    wait_done(2);
    chk("err_frame_f2", n_err_frame, 0);

    // Frame 3: vsync coincident with an active pixel during row 2
    vsync_pulse();
    line(H, 0);
    line(H, 1);
    for (int i = 0; i < 3; i++) begin
      i_blank = 1'b1;
      q.push_back(exp_pix(2, i));
      tick();
    end
    i_vsync = 1'b1;
    q.push_back(exp_pix(0, 0));
    tick();
    i_vsync = 1'b0;
    for (int i = 1; i < H; i++) begin
      q.push_back(exp_pix(0, i));
      tick();
    end
    i_blank = 1'b0;
    repeat (3) tick();
    chk("err_frame_mid", n_err_frame, 1);
    chk("err_line_restart", n_err_line, 2);
    for (int r = 1; r < V; r++) line(H, r);
    push_flush();
    wait_done(3);

    // Frame 4: reset in the middle of the flush line
    vsync_pulse();
    for (int r = 0; r < V; r++) line(H, r);
    push_flush();
    begin
      int k = 0;
      while (!o_bot_sel && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("flush_seen", o_bot_sel, 1);
    end
    tick();
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_zero("reset_mid_flush");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("no_done_after_reset", n_done, 3);
    chk_zero("idle_after_reset");

    // Frame 5: recovery
    clr_counts();
    vsync_pulse();
    for (int r = 0; r < V; r++) line(H, r);
    push_flush();
    wait_done(4);
    chk("wr0_cnt_f5", n_wr0, 32);
    chk("rd1_cnt_f5", n_rd1, 24);
    chk("err_frame_total", n_err_frame, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
